// File: rtl/simon64_96_key_expand_pkg.sv
// Shared constants, FSM states and helpers for the SIMON 64/96 key schedule.
package simon64_96_pkg;
    localparam int WORD      = 32;
    localparam int ROUNDS    = 42;
    localparam int KEY_WORDS = 3;

    localparam logic [WORD-1:0] C = 32'hFFFFFFFC;
    // Literal written leftmost-first; z2[j] lives at bit 61-j.
    localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_e;

    function automatic logic z2_bit(input logic [5:0] j);
        return Z2[6'd61 - j];
    endfunction
endpackage

// File: rtl/simon64_96_key_expand_if.sv
// Request/read bus between a key-schedule consumer and the expander.
interface simon64_96_key_expand_if;
    import simon64_96_pkg::*;

    logic                          start;
    logic [KEY_WORDS*WORD-1:0]     key;
    logic                          busy;
    logic                          keyReady;
    logic [5:0]                    rdAddr;
    logic [WORD-1:0]               rdData;

    modport master (output start, key, rdAddr, input busy, keyReady, rdData);
    modport slave  (input start, key, rdAddr, output busy, keyReady, rdData);
endinterface

// File: rtl/simon64_96_key_expand_step.sv
// One SIMON key-schedule step for m=3 key words; pure XOR/rotate, usable by any word width.
module simon_key_step #(
    parameter int              WORD    = 32,
    parameter logic [WORD-1:0] C_CONST = 32'hFFFFFFFC
) (
    input  logic [WORD-1:0] rk_im1,
    input  logic [WORD-1:0] rk_im3,
    input  logic            z_bit,
    output logic [WORD-1:0] rk_new
);
    logic [WORD-1:0] t;
    logic [WORD-1:0] t_r1;

    always_comb begin
        t      = {rk_im1[2:0], rk_im1[WORD-1:3]};
        t_r1   = {t[0], t[WORD-1:1]};
        rk_new = C_CONST ^ {{(WORD-1){1'b0}}, z_bit} ^ rk_im3 ^ t ^ t_r1;
    end
endmodule

// File: rtl/simon64_96_key_expand.sv
// SIMON 64/96 round-key expander: one key per cycle into a 42-entry register file
// with a registered read port.
module simon64_96_key_expand #(
    parameter int WORD   = 32,
    parameter int ROUNDS = 42
) (
    input  logic                           clk,
    input  logic                           reset,
    simon64_96_key_expand_if.slave         bus
);
    import simon64_96_pkg::*;

    localparam logic [5:0] LAST = 6'(ROUNDS - 1);

    state_e          state_q, state_d;
    logic [5:0]      idx_q, idx_d;
    logic [WORD-1:0] rd_data_q, rd_data_d;
    logic [WORD-1:0] rk_q [ROUNDS];

    logic            key_ld;
    logic            step_we;
    logic [WORD-1:0] step_out;

    simon_key_step #(.WORD(WORD), .C_CONST(C)) u_step (
        .rk_im1 (rk_q[idx_q - 6'd1]),
        .rk_im3 (rk_q[idx_q - 6'd3]),
        .z_bit  (z2_bit(idx_q - 6'd3)),
        .rk_new (step_out)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        key_ld  = 1'b0;
        step_we = 1'b0;
        case (state_q)
            IDLE, READY: begin
                if (bus.start) begin
                    key_ld  = 1'b1;
                    idx_d   = 6'd3;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                // start is deliberately not looked at here
                step_we = 1'b1;
                idx_d   = idx_q + 6'd1;
                if (idx_q == LAST) state_d = READY;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_data_d = '0;
        if (bus.rdAddr < 6'(ROUNDS)) rd_data_d = rk_q[bus.rdAddr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= 6'd3;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage is left uncleared by reset; keyReady alone qualifies its contents.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (key_ld) begin
                rk_q[0] <= bus.key[WORD-1:0];
                rk_q[1] <= bus.key[2*WORD-1:WORD];
                rk_q[2] <= bus.key[3*WORD-1:2*WORD];
            end else if (step_we) begin
                rk_q[idx_q] <= step_out;
            end
        end
    end

    assign bus.busy     = (state_q == EXPAND);
    assign bus.keyReady = (state_q == READY);
    assign bus.rdData   = rd_data_q;
endmodule

// File: tb/tb_simon64_96_key_expand.sv
// Self-checking bench for simon64_96_key_expand against a string-driven key-schedule model.
module tb_simon64_96_key_expand;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    logic [31:0] exp_rk [42];
    logic [31:0] got_rk [42];

    simon64_96_key_expand_if ifc ();

    simon64_96_key_expand dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rr(input logic [31:0] x, input int s);
        return (x >> s) | (x << (32 - s));
    endfunction

    function automatic logic [31:0] rl(input logic [31:0] x, input int s);
        return (x << s) | (x >> (32 - s));
    endfunction

    // k[i+3] = ~3 ^ z2[i] ^ k[i] ^ (S^-3 ^ S^-4) k[i+2]
    function automatic void build_model(input logic [95:0] k);
        string z2s;
        logic [31:0] zc;
        z2s = "10101111011100000011010010011000101000010001111110010110110011";
        exp_rk[0] = k[31:0];
        exp_rk[1] = k[63:32];
        exp_rk[2] = k[95:64];
        for (int i = 3; i < 42; i++) begin
            zc = (z2s.getc(i - 3) == "1") ? 32'd1 : 32'd0;
            exp_rk[i] = ~32'd3 ^ zc ^ exp_rk[i-3] ^ rr(exp_rk[i-1], 3) ^ rr(exp_rk[i-1], 4);
        end
    endfunction

    function automatic logic [63:0] encrypt(input logic [63:0] pt);
        logic [31:0] x, y, tmp;
        x = pt[63:32];
        y = pt[31:0];
        for (int r = 0; r < 42; r++) begin
            tmp = x;
            x   = y ^ (rl(x, 1) & rl(x, 8)) ^ rl(x, 2) ^ got_rk[r];
            y   = tmp;
        end
        return {x, y};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [95:0] k);
        ifc.key   = k;
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        ifc.key   = $urandom();
    endtask

    task automatic wait_ready(output int edges, output int busy_cnt);
        edges    = 0;
        busy_cnt = ifc.busy ? 1 : 0;
        while (!ifc.keyReady && edges < 100) begin
            tick();
            edges++;
            if (ifc.busy) busy_cnt++;
        end
    endtask

    task automatic read_all();
        for (int a = 0; a < 42; a++) begin
            ifc.rdAddr = 6'(a);
            tick();
            got_rk[a] = ifc.rdData;
        end
    endtask

    task automatic check_all(input string tag);
        for (int a = 0; a < 42; a++) begin
            n_cmp++;
            if (got_rk[a] !== exp_rk[a]) begin
                n_bad++;
                $display("FAIL %s rk[%0d]: got %h expected %h", tag, a, got_rk[a], exp_rk[a]);
            end
        end
    endtask

    task automatic check_latency(input string tag, input int edges, input int busy_cnt);
        n_cmp++;
        if (edges !== 39) begin
            n_bad++;
            $display("FAIL %s ready_edges: got %0d expected 39", tag, edges);
        end
        n_cmp++;
        if (busy_cnt !== 39) begin
            n_bad++;
            $display("FAIL %s busy_cycles: got %0d expected 39", tag, busy_cnt);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        ifc.start = 1'b1;
        ifc.key   = 96'h0;
        ifc.rdAddr = 6'd0;
        tick();
        tick();
        n_cmp++;
        if ({ifc.busy, ifc.keyReady} !== 2'b00 || ifc.rdData !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_state: got busy=%b ready=%b rd=%h expected 0 0 0",
                     ifc.busy, ifc.keyReady, ifc.rdData);
        end
        ifc.start = 1'b0;
        reset     = 1'b0;
        tick();
        n_cmp++;
        if ({ifc.busy, ifc.keyReady} !== 2'b00) begin
            n_bad++;
            $display("FAIL idle_after_reset: got busy=%b ready=%b expected 0 0", ifc.busy, ifc.keyReady);
        end
    endtask

    task automatic test_known_vector();
        int edges, bc;
        logic [63:0] ct;
        logic [31:0] spot [4];
        spot[0] = 32'h03020100; spot[1] = 32'h0b0a0908;
        spot[2] = 32'h13121110; spot[3] = 32'hffae9dce;
        accept(96'h131211100b0a090803020100);
        wait_ready(edges, bc);
        check_latency("known", edges, bc);
        read_all();
        for (int a = 0; a < 4; a++) begin
            n_cmp++;
            if (got_rk[a] !== spot[a]) begin
                n_bad++;
                $display("FAIL known_spot rk[%0d]: got %h expected %h", a, got_rk[a], spot[a]);
            end
        end
        build_model(96'h131211100b0a090803020100);
        check_all("known");
        ct = encrypt(64'h6f7220676e696c63);
        n_cmp++;
        if (ct !== 64'h5ca2e27f111a8fc8) begin
            n_bad++;
            $display("FAIL known_cipher: got %h expected 5ca2e27f111a8fc8", ct);
        end
    endtask

    task automatic test_random_keys();
        int edges, bc;
        logic [95:0] keys [4];
        keys[0] = 96'h51b4e07ffd3067d270dd4dc0;
        keys[1] = 96'h0a44881ec268860d74deac5a;
        keys[2] = {$urandom(), $urandom(), $urandom()};
        keys[3] = {$urandom(), $urandom(), $urandom()};
        for (int n = 0; n < 4; n++) begin
            accept(keys[n]);
            wait_ready(edges, bc);
            check_latency("rand", edges, bc);
            read_all();
            build_model(keys[n]);
            check_all("rand");
        end
    endtask

    task automatic test_ignore_start();
        int edges, bc;
        logic [95:0] ka, kb;
        ka = {$urandom(), $urandom(), $urandom()};
        kb = ~ka;
        accept(ka);
        edges = 0;
        bc    = 1;
        while (!ifc.keyReady && edges < 100) begin
            if (edges == 9) begin
                ifc.key   = kb;
                ifc.start = 1'b1;
            end
            tick();
            ifc.start = 1'b0;
            edges++;
            if (ifc.busy) bc++;
        end
        check_latency("ignore", edges, bc);
        read_all();
        build_model(ka);
        check_all("ignore");
    endtask

    task automatic test_abort();
        int edges, bc;
        logic [95:0] ka, kb;
        ka = {$urandom(), $urandom(), $urandom()};
        kb = {$urandom(), $urandom(), $urandom()};
        accept(ka);
        for (int c = 0; c < 20; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if ({ifc.busy, ifc.keyReady} !== 2'b00 || ifc.rdData !== 32'h0) begin
            n_bad++;
            $display("FAIL abort_reset: got busy=%b ready=%b rd=%h expected 0 0 0",
                     ifc.busy, ifc.keyReady, ifc.rdData);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++;
            if (ifc.keyReady !== 1'b0) begin
                n_bad++;
                $display("FAIL abort_ready_low: got %b expected 0", ifc.keyReady);
            end
        end
        accept(kb);
        wait_ready(edges, bc);
        check_latency("abort", edges, bc);
        read_all();
        build_model(kb);
        check_all("abort");
    endtask

    task automatic test_ready_restart();
        int edges, bc;
        logic [95:0] kn;
        logic [5:0]  oob [2];
        oob[0] = 6'd42;
        oob[1] = 6'd63;
        for (int n = 0; n < 2; n++) begin
            ifc.rdAddr = oob[n];
            tick();
            n_cmp++;
            if (ifc.rdData !== 32'h0) begin
                n_bad++;
                $display("FAIL oob_read addr %0d: got %h expected 0", oob[n], ifc.rdData);
            end
        end
        n_cmp++;
        if (ifc.keyReady !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_before_restart: got %b expected 1", ifc.keyReady);
        end
        kn = {$urandom(), $urandom(), $urandom()};
        accept(kn);
        n_cmp++;
        if (ifc.keyReady !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_drop: got %b expected 0", ifc.keyReady);
        end
        wait_ready(edges, bc);
        check_latency("restart", edges, bc);
        read_all();
        build_model(kn);
        check_all("restart");
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        ifc.start  = 1'b0;
        ifc.key    = '0;
        ifc.rdAddr = '0;
        reset      = 1'b1;
        test_reset();
        test_known_vector();
        test_random_keys();
        test_ignore_start();
        test_abort();
        test_ready_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/simon64_96_key_expand.md
SIMON64_96_KEY_EXPAND -- requirements
Module: simon64_96_key_expand

Interface
REQ-001 Parameter WORD, default 32, round-key word width in bits (fixed n for SIMON64).
REQ-002 Parameter ROUNDS, default 42, number of round keys produced (T for SIMON 64/96).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to expand key.
REQ-006 key  input  96  master key; key[31:0]=k0, key[63:32]=k1, key[95:64]=k2.
REQ-007 busy  output  1  high while expansion is in progress.
REQ-008 keyReady  output  1  high while all ROUNDS round keys are valid.
REQ-009 rdAddr  input  6  round-key index to read, 0..41.
REQ-010 rdData  output  32  registered round key at rdAddr.

Function
REQ-011 The FSM SHALL have states IDLE, EXPAND, READY; busy=1 only in EXPAND; keyReady=1 only in READY.
REQ-012 In IDLE or READY, start=1 SHALL capture k0,k1,k2 into rk[0],rk[1],rk[2], set counter i=3, enter EXPAND, and drop keyReady on the next cycle.
REQ-013 start asserted during EXPAND SHALL be ignored; key SHALL be sampled only in the start-accept cycle.
REQ-014 Each EXPAND cycle SHALL write rk[i] = c ^ z2[i-3] ^ rk[i-3] ^ t ^ ROR(t,1), with t = ROR(rk[i-1],3) and c = 32'hFFFFFFFC, then increment i.
REQ-015 z2 SHALL be the 62-bit constant 10101111011100000011010010011000101000010001111110010110110011, bit index 0 = leftmost; i-3 < 62 always, so no wrap logic is required.
REQ-016 All rotations SHALL be 32-bit rotate-right; arithmetic SHALL be pure XOR/NOT, no carries.
REQ-017 After writing rk[41] (i=41), the FSM SHALL enter READY; keyReady SHALL rise exactly 39 clock edges after the start-accept edge.
REQ-018 rdData SHALL equal rk[rdAddr] one cycle after rdAddr is presented (1-cycle read latency), in every state.
REQ-019 rdAddr > 41 SHALL return 32'h0 on rdData.
REQ-020 rdData contents are defined only while keyReady=1; during EXPAND the stored value, possibly stale, is returned.
REQ-021 A start in READY SHALL re-expand: keyReady=0 from the next cycle until the new expansion completes.
REQ-022 Consumers SHALL read rk[r] for encryption round r and rk[41-r] for decryption round r; this block imposes no read-order restriction.

Reset
REQ-023 reset=1 SHALL force state IDLE, i=3, busy=0, keyReady=0, rdData=0 on the next edge, overriding start.
REQ-024 Reset mid-EXPAND SHALL abort expansion; round-key storage need not be cleared, but keyReady SHALL stay 0 until a full new expansion finishes.

Structure
REQ-025 A shared package simon64_96_pkg SHALL hold WORD, ROUNDS, KEY_WORDS=3, constant C=32'hFFFFFFFC, the Z2 constant, and the FSM state enumeration.
REQ-026 The single-step round-key function from REQ-014 SHALL be a combinational sub-module, simon_key_step, reusable by other SIMON variants.
REQ-027 Round-key storage SHALL be a 42x32 register array, with one write port and one registered read port.

Verification
REQ-028 Key 96'h131211100b0a090803020100, start pulse -> keyReady after 39 edges; rdAddr 0,1,2,3 -> 32'h03020100, 32'h0b0a0908, 32'h13121110, 32'hffae9dce.
REQ-029 Keys 96'h51b4e07ffd3067d270dd4dc0 and 96'h0a44881ec268860d74deac5a -> all 42 rdData values match the bench reference model; round keys fed to a round model reproduce ciphertexts 64'h8de637a082160b57 and 64'h731a0b7101efa776.
REQ-030 Second start pulse 10 cycles into EXPAND with a different key -> ignored; results equal those for the first key; busy high for exactly 39 cycles.
REQ-031 reset asserted at cycle 20 of EXPAND, then a new start -> keyReady=0 throughout the abort; after the new expansion, round keys match the model for the new key.
REQ-032 In READY: rdAddr=6'd42 and 6'd63 -> rdData=0; start with a new key -> keyReady drops on the next cycle and rises again 39 edges after the accept edge.
